// File: rtl/register_read_stage_if.sv
// Handshake and register-write bus between the instruction source, the
// register-read stage and the downstream consumer.
interface register_read_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  // Valid/ready rule for both channels: a transfer happens on a rising clk edge
  // where valid and ready are both 1. Once valid rises, the source holds it and
  // its payload steady until that edge. Ready may change freely.
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instruction;

  logic                  write_enabled;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [2:0]            ALU_operation;
  logic                  illegal;

  modport master (
    output instr_valid, instruction,
    output write_enabled, write_address, write_data,
    output out_ready,
    input  instr_ready,
    input  out_valid, rs_data, rt_data, rd_address, ALU_operation, illegal
  );

  modport slave (
    input  instr_valid, instruction,
    input  write_enabled, write_address, write_data,
    input  out_ready,
    output instr_ready,
    output out_valid, rs_data, rt_data, rd_address, ALU_operation, illegal
  );
endinterface

// File: rtl/register_read_stage.sv
// R-format register-read stage: decodes one instruction, reads rs then rt
// through the single read port of the owned register file, and holds the result.
module register_read_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_input,
  register_read_stage_if.slave  bus,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ_RS = 2'd1,
    S_READ_RT = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  state_t                r_state;
  state_t                w_next_state;

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic [ADDR_WIDTH-1:0] r_rs_addr;
  logic [ADDR_WIDTH-1:0] r_rt_addr;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [DATA_WIDTH-1:0] r_rt_data;
  logic [ADDR_WIDTH-1:0] r_rd_address;
  logic [2:0]            r_alu_op;
  logic                  r_illegal;

  logic                  w_accept;
  logic                  w_write_hit_file;
  logic [5:0]            w_opcode;
  logic [5:0]            w_funct;
  logic [2:0]            w_alu_op;
  logic                  w_illegal;
  logic [ADDR_WIDTH-1:0] w_read_addr;
  logic [DATA_WIDTH-1:0] w_read_data;

  assign w_accept         = (r_state == S_IDLE) && bus.instr_valid;
  assign w_write_hit_file = bus.write_enabled && (bus.write_address != '0);
  assign w_opcode         = bus.instruction[31:26];
  assign w_funct          = bus.instruction[5:0];

  // Decode of the offered word; only captured on the accepting edge.
  always_comb begin
    w_alu_op  = 3'b000;
    w_illegal = 1'b0;
    if (w_opcode != 6'd0) begin
      w_illegal = 1'b1;
    end else begin
      case (w_funct)
        FUNCT_ADD: w_alu_op = 3'b000;
        FUNCT_SUB: w_alu_op = 3'b001;
        FUNCT_AND: w_alu_op = 3'b010;
        FUNCT_OR:  w_alu_op = 3'b011;
        FUNCT_SLT: w_alu_op = 3'b100;
        default:   w_illegal = 1'b1;
      endcase
    end
  end

  // Single read port, shared by the two read states. A same-cycle write to the
  // addressed register is forwarded so the operand never misses it.
  always_comb begin
    w_read_addr = (r_state == S_READ_RS) ? r_rs_addr : r_rt_addr;
    if (w_read_addr == '0) begin
      w_read_data = '0;
    end else if (w_write_hit_file && (bus.write_address == w_read_addr)) begin
      w_read_data = bus.write_data;
    end else begin
      w_read_data = r_regs[w_read_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_input) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_write_hit_file) begin
      r_regs[bus.write_address] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_input) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (bus.instr_valid) w_next_state = S_READ_RS;
      S_READ_RS: w_next_state = S_READ_RT;
      S_READ_RT: w_next_state = S_HOLD;
      S_HOLD:    if (bus.out_ready) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_input) begin
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_rd_address <= '0;
      r_alu_op     <= 3'b000;
      r_illegal    <= 1'b0;
    end else if (w_accept) begin
      r_rs_addr    <= bus.instruction[25:21];
      r_rt_addr    <= bus.instruction[20:16];
      r_rd_address <= bus.instruction[15:11];
      r_alu_op     <= w_alu_op;
      r_illegal    <= w_illegal;
    end
  end

  // Operands are captured once; later writes do not revise them.
  always_ff @(posedge clk) begin
    if (!reset_input) begin
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else begin
      if (r_state == S_READ_RS) r_rs_data <= w_read_data;
      if (r_state == S_READ_RT) r_rt_data <= w_read_data;
    end
  end

  always_comb begin
    bus.instr_ready   = (r_state == S_IDLE);
    bus.out_valid     = (r_state == S_HOLD);
    bus.rs_data       = r_rs_data;
    bus.rt_data       = r_rt_data;
    bus.rd_address    = r_rd_address;
    bus.ALU_operation = r_alu_op;
    bus.illegal       = r_illegal;
    o_state           = r_state;
  end

endmodule

// File: doc/register_read_stage.md
Name: register_read_stage

Overview:
- Front half of the R-format execute path: accepts one 32-bit R-format instruction and decodes rs/rt/rd/funct.
- Fetches both source operands from an internal register file over a single read port, then presents operands, destination address and a 3-bit ALU operation downstream.
- Owns the register file; the register-write path updates it through the write port.
- Register 0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, register and operand width
ADDR_WIDTH, 5, register address width
REG_COUNT, 32, number of registers (2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset_input  input  1  synchronous, active-low reset
instr_valid  input  1  instruction offered
instr_ready  output  1  stage can accept an instruction
instruction  input  32  R-format word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [5:0] funct
write_enabled  input  1  register-file write strobe
write_address  input  ADDR_WIDTH  write target
write_data  input  DATA_WIDTH  write value
out_valid  output  1  decoded operands available
out_ready  input  1  downstream accepts
rs_data  output  DATA_WIDTH  operand A
rt_data  output  DATA_WIDTH  operand B
rd_address  output  ADDR_WIDTH  destination register
ALU_operation  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
illegal  output  1  unsupported opcode or funct

Behaviour:
- Reset (reset_input=0 at a clk edge):
  - All registers cleared to 0.
  - FSM goes to IDLE.
  - instr_ready=1; out_valid, rs_data, rt_data, rd_address, ALU_operation and illegal are all 0.
  - Reset overrides everything else in the same cycle, including a write and a mid-operation read; any in-flight instruction is dropped.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid, latch the instruction and go to READ_RS.
  - READ_RS: instr_ready=0. Latch rs_data, then go to READ_RT.
  - READ_RT: latch rt_data, then go to HOLD.
  - HOLD: out_valid=1. On out_ready, go to IDLE. Outputs stay stable while out_ready=0.
- Latency:
  - Acceptance edge E0; rs latched at E1; rt latched at E2.
  - out_valid is high from E2 until the handshake edge.
  - Minimum cycle per instruction is 4 (IDLE→READ_RS→READ_RT→HOLD→IDLE). There is no back-to-back accept in HOLD.
- Register file:
  - One write per cycle, taken when write_enabled=1 and write_address≠0.
  - Writes to register 0 are ignored; register 0 always reads 0.
  - Writes are accepted in every state.
- Bypass: in READ_RS or READ_RT, if write_enabled=1 and write_address equals the register being read (and is nonzero), the latched operand is write_data from that same cycle.
- Writes landing after an operand is latched do not change rs_data/rt_data (no retroactive update).
- rs==rt is legal: both operands read the same register in successive cycles, and the bypass applies to each read independently.
- Decode:
  - opcode≠0, or funct not in {0x20, 0x22, 0x24, 0x25, 0x2A}, sets illegal=1 and ALU_operation=000.
  - Operands are still read and the handshake completes normally.
  - Valid funct values map 0x20→000, 0x22→001, 0x24→010, 0x25→011, 0x2A→100.
- rd_address, ALU_operation and illegal are registered at E0 and held until the next acceptance.
- instr_valid outside IDLE is ignored; the instruction is not consumed.

Test Plan:
- Reset, then write r1=31 and r2=47; issue add with rs=1, rt=2, rd=3 (0x00221820); hold out_ready=1 → out_valid at E2, rs_data=31, rt_data=47, rd_address=3, ALU_operation=000, illegal=0.
- Write r5=0x10 at the READ_RS cycle of an instruction with rs=5 → rs_data=0x10 (bypass); a write of r5=0x99 during HOLD leaves rs_data=0x10.
- Write r0=0xFFFFFFFF, then read rs=0, rt=0 → both operands 0.
- out_ready held 0 for 5 cycles in HOLD → outputs stable and instr_ready=0; a new instr_valid is ignored; releasing out_ready returns the FSM to IDLE in 1 cycle.
- funct=0x08 → illegal=1, ALU_operation=000; opcode=0x23 → illegal=1; funct=0x2A → ALU_operation=100, illegal=0.
- reset_input=0 during READ_RT → next cycle IDLE, out_valid=0, all registers read back 0.
